// File: rtl/seg7_pattern_decoder_if.sv
// ============================================================================
// Module      : seg7_pattern_decoder_if
// Description : Decoded-digit valid/ready channel of the segment pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_pattern_decoder_if;
    logic [3:0] out_digit;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_digit,
        output out_err,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_digit,
        input  out_err,
        input  out_valid,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/seg7_pattern_decoder.sv
// ============================================================================
// Module      : seg7_pattern_decoder
// Description : Debounces a 7-segment pattern bus, decodes it to a digit and
//               delivers it over a one-entry valid/ready register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en,
    input  wire logic [6:0]            seg_in,
    seg7_pattern_decoder_if.master     out_if,
    output logic                       overrun,
    input  wire logic                  clr_ovr,
    output logic [7:0]                 digit_count
);

    localparam logic [7:0] C_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [6:0] C_SEG_BLANK = 7'h00;

    logic [6:0] prev_q,    prev_d;
    logic [7:0] cnt_q,     cnt_d;
    logic       armed_q,   armed_d;
    logic [3:0] digit_q,   digit_d;
    logic       err_q,     err_d;
    logic       valid_q,   valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] count_q,   count_d;

    logic       w_event;
    logic       w_handshake;
    logic [3:0] w_dec_digit;
    logic       w_dec_err;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc   = cnt_q + 8'd1;
    assign w_handshake = valid_q & out_if.out_ready;

    // The event fires on an edge where seg_in already equals prev_q, so prev_q is what gets decoded.
    always_comb begin
        w_dec_digit = 4'hF;
        w_dec_err   = 1'b0;
        case (prev_q)
            7'h3F:   w_dec_digit = 4'd0;
            7'h06:   w_dec_digit = 4'd1;
            7'h5B:   w_dec_digit = 4'd2;
            7'h4F:   w_dec_digit = 4'd3;
            7'h66:   w_dec_digit = 4'd4;
            7'h6D:   w_dec_digit = 4'd5;
            7'h7D:   w_dec_digit = 4'd6;
            7'h07:   w_dec_digit = 4'd7;
            7'h7F:   w_dec_digit = 4'd8;
            7'h6F:   w_dec_digit = 4'd9;
            default: w_dec_err   = 1'b1;
        endcase
    end

    always_comb begin
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        digit_d   = digit_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        w_event   = 1'b0;

        if (en) begin
            if (seg_in != prev_q) begin
                prev_d  = seg_in;
                cnt_d   = 8'd0;
                armed_d = 1'b1;
            end else if (armed_q) begin
                cnt_d = w_cnt_inc;
                if (w_cnt_inc == C_STABLE) begin
                    w_event = 1'b1;
                    armed_d = 1'b0;
                end
            end
        end

        // A blank bus is a real event but never produces output or an overrun.
        if (w_event && (prev_q != C_SEG_BLANK)) begin
            if (!valid_q || out_if.out_ready) begin
                digit_d = w_dec_digit;
                err_d   = w_dec_err;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (w_handshake) begin
            valid_d = 1'b0;
        end

        if (clr_ovr && (overrun_d == overrun_q)) begin
            overrun_d = 1'b0;
        end
        if (w_handshake && !err_q) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= C_SEG_BLANK;
            cnt_q     <= 8'd0;
            armed_q   <= 1'b0;
            digit_q   <= 4'd0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            digit_q   <= digit_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign out_if.out_digit = digit_q;
    assign out_if.out_err   = err_q;
    assign out_if.out_valid = valid_q;
    assign overrun          = overrun_q;
    assign digit_count      = count_q;

endmodule

`default_nettype wire
